regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the CPU datapath, successor to the single-write, two-read 32x32 file.
- Adds configurable width, depth and read-port count, a second write port for load writeback, and write-to-read bypass.
- Replaces the one-cycle bulk reset with a sequential clear engine and a Ready handshake; the engine can also be triggered at run time.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, synchronous, active-high.
- ReadReg  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NREAD*DATA_W  read data, combinational, packed the same way as ReadReg.
- WE0  in  1  write enable, port 0 (ALU writeback).
- WriteReg0  in  ADDR_W  write address, port 0.
- WriteData0  in  DATA_W  write data, port 0.
- WE1  in  1  write enable, port 1 (load writeback).
- WriteReg1  in  ADDR_W  write address, port 1.
- WriteData1  in  DATA_W  write data, port 1.
- Clr  in  1  run-time soft-clear request, single-cycle pulse.
- Ready  out  1  high when the file is accepting writes and returning stored data.

Behaviour:
- State machine, two states:
  - CLEAR: owns the array; one entry is zeroed per cycle.
  - IDLE: normal operation.
- Clear pointer: ptr, ADDR_W bits.
- Reset (clrn=1 at an edge):
  - Next state is CLEAR with ptr=0 and Ready=0.
  - No array write occurs on the reset edge.
  - Applies from any state, including mid-clear; ptr restarts at 0.
- CLEAR:
  - Each edge writes 0 to entry ptr, then increments ptr.
  - At ptr==DEPTH-1, that edge zeroes the last entry and moves to IDLE.
  - Clear therefore takes exactly DEPTH edges after reset deasserts. Ready rises on the DEPTH-th such edge; with DEPTH=32, Ready=1 on edge 32.
- Ready is a registered output: 0 in reset and in CLEAR, 1 in IDLE.
- Clr in IDLE: moves to CLEAR with ptr=0 on the next edge, Ready=0 from that edge. Any write presented in the same cycle as Clr is discarded.
- Clr in CLEAR: ignored; no restart.
- While Ready=0:
  - WE0 and WE1 are ignored.
  - All ReadData outputs are 0, whatever the partially cleared contents.
- Writes in IDLE:
  - WEn=1 writes WriteDatan to entry WriteRegn at the edge.
  - With ZERO_REG=1, address 0 is never written.
  - Both ports enabled with the same address: port 1 wins, port 0's write is dropped.
  - Different addresses: both writes commit in the same edge.
- Reads in IDLE, combinational, for each port k:
  - Address 0 with ZERO_REG=1: returns 0.
  - Else, with BYPASS=1:
    - WE1 set and WriteReg1 matches: returns WriteData1.
    - Else WE0 set and WriteReg0 matches: returns WriteData0.
    - Else: returns the array entry.
  - Bypass priority matches write priority.
  - With BYPASS=0: reads return the array entry only; new data is visible one cycle after the write edge.
- The array itself has no reset values; contents are defined only after a clear completes.
- No X may propagate from ReadData when Ready=1 after any clear.

Decomposition:
- regfile_pkg holds:
  - the state enum {ST_IDLE, ST_CLEAR};
  - localparams for default DATA_W and ADDR_W;
  - a depth function computing 2**ADDR_W.
- One natural sub-module: regfile_read_port. It covers zero-register masking, the two-level bypass mux and Ready gating, and is instantiated NREAD times via generate.
- Array storage, write arbitration and the clear FSM stay in regfile_mp.

Test Plan:
- Reset: pulse clrn for 2 cycles, then hold 0. Required: Ready=0 for edges 1..31 and Ready=1 at edge 32. Every register then reads 0, including registers written before reset.
- Dual write, same address: WE0=WE1=1, WriteReg0=WriteReg1=5, WriteData0=0x1111_1111, WriteData1=0x2222_2222. Required: ReadReg=5 returns 0x2222_2222 in the same cycle (bypass) and on every later cycle.
- Write to register 0: WE0=1, WriteReg0=0, WriteData0=0xDEAD_BEEF. Required: ReadData for address 0 is 0 in that cycle and afterwards.
- Parallel writes: WE0 writes reg3=0xA, WE1 writes reg7=0xB in the same cycle. Required: the next cycle reads reg3=0xA and reg7=0xB. Repeat with BYPASS=0: the write cycle returns the old values.
- Soft clear mid-run: write reg9=0x55, pulse Clr together with WE0 writing reg10=0x77. Required:
  - Ready=0 for 32 cycles; all reads return 0 and writes are ignored meanwhile.
  - Afterwards reg9=0 and reg10=0.
- Reset mid-clear: assert clrn at clear cycle 12. Required: ptr restarts and Ready rises exactly 32 edges after clrn deasserts. A second Clr pulse during clear does not extend the 32-cycle window.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file:
//   regState_t      - clear engine state (ST_IDLE, ST_CLEAR)
//   DEFAULT_DATA_W  - default register width
//   DEFAULT_ADDR_W  - default address width
//   regDepth()      - number of entries for a given address width
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } regState_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Entry count is always a full power of two so the clear pointer can
  // sweep the whole address space without a separate limit register.
  function automatic int regDepth(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port of the register file.
// Ports:
//   ready                      - file holds valid contents; outputs 0 otherwise
//   readReg                    - read address
//   arrayData                  - stored entry at readReg
//   we0/writeReg0/writeData0   - committing write on port 0 (ALU writeback)
//   we1/writeReg1/writeData1   - committing write on port 1 (load writeback)
//   readData                   - returned value
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] readReg,
  input  logic [DATA_W-1:0] arrayData,
  input  logic              we0,
  input  logic [ADDR_W-1:0] writeReg0,
  input  logic [DATA_W-1:0] writeData0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] writeReg1,
  input  logic [DATA_W-1:0] writeData1,
  output logic [DATA_W-1:0] readData
);

  logic hit0;
  logic hit1;
  logic isZero;

  // Read selection. Zero-register masking and the not-ready blanking take
  // precedence over everything, so a half-cleared array never leaks out.
  // Port 1 is checked before port 0 so forwarding agrees with which write
  // actually lands in the array when both target the same entry.
  always_comb begin
    hit0     = we0 && (writeReg0 == readReg);
    hit1     = we1 && (writeReg1 == readReg);
    isZero   = (ZERO_REG != 0) && (readReg == '0);
    readData = '0;
    if (!ready || isZero) begin
      readData = '0;
    end else if ((BYPASS != 0) && hit1) begin
      readData = writeData1;
    end else if ((BYPASS != 0) && hit0) begin
      readData = writeData0;
    end else begin
      readData = arrayData;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port register file with two write ports, optional
// write-to-read bypass and a sequential clear engine.
// Ports:
//   CLK        - clock, rising edge
//   clrn       - synchronous active-high reset; restarts the clear engine
//   ReadReg    - NREAD packed read addresses
//   ReadData   - NREAD packed read results (combinational)
//   WE0/WriteReg0/WriteData0 - write port 0 (ALU writeback)
//   WE1/WriteReg1/WriteData1 - write port 1 (load writeback)
//   Clr        - run-time clear request pulse
//   Ready      - registered; high once the array has been fully cleared
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    CLK,
  input  logic                    clrn,
  input  logic [NREAD*ADDR_W-1:0] ReadReg,
  output logic [NREAD*DATA_W-1:0] ReadData,
  input  logic                    WE0,
  input  logic [ADDR_W-1:0]       WriteReg0,
  input  logic [DATA_W-1:0]       WriteData0,
  input  logic                    WE1,
  input  logic [ADDR_W-1:0]       WriteReg1,
  input  logic [DATA_W-1:0]       WriteData1,
  input  logic                    Clr,
  output logic                    Ready
);

  localparam int DEPTH = regDepth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regArray [DEPTH];
  regState_t         state;
  logic [ADDR_W-1:0] ptr;
  logic              writeOpen;
  logic              fwd0;
  logic              fwd1;
  logic              commit0;
  logic              commit1;

  // A write only counts when the file is live and no clear is being
  // requested in the same cycle. Register 0 is never stored when it is
  // hardwired, and port 0 yields to port 1 on an address collision.
  always_comb begin
    writeOpen = Ready && !Clr;
    fwd0      = writeOpen && WE0;
    fwd1      = writeOpen && WE1;
    commit0   = fwd0 && !((ZERO_REG != 0) && (WriteReg0 == '0))
                     && !(WE1 && (WriteReg1 == WriteReg0));
    commit1   = fwd1 && !((ZERO_REG != 0) && (WriteReg1 == '0));
  end

  // Clear engine. Reset or a Clr pulse in IDLE parks the pointer at 0 and
  // drops Ready; each CLEAR edge advances the pointer, and the edge that
  // zeroes the last entry hands the array back and raises Ready. Clr seen
  // while already clearing is ignored so the window never stretches.
  always_ff @(posedge CLK) begin
    if (clrn) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      Ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            state <= ST_IDLE;
            Ready <= 1'b1;
          end
        end
        default: begin
          if (Clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            Ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array storage has no reset of its own; contents become defined through
  // the clear engine. The reset edge itself leaves the array untouched.
  // Port 1 is written last, though commit0 already excludes collisions.
  always_ff @(posedge CLK) begin
    if (!clrn) begin
      if (state == ST_CLEAR) begin
        regArray[ptr] <= '0;
      end else begin
        if (commit0) begin
          regArray[WriteReg0] <= WriteData0;
        end
        if (commit1) begin
          regArray[WriteReg1] <= WriteData1;
        end
      end
    end
  end

  // One read port per packed address slice; forwarding is fed with the
  // committing enables so data that will be discarded is never returned.
  for (genvar k = 0; k < NREAD; k++) begin : gRead
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) uReadPort (
      .ready     (Ready),
      .readReg   (ReadReg[k*ADDR_W +: ADDR_W]),
      .arrayData (regArray[ReadReg[k*ADDR_W +: ADDR_W]]),
      .we0       (fwd0),
      .writeReg0 (WriteReg0),
      .writeData0(WriteData0),
      .we1       (fwd1),
      .writeReg1 (WriteReg1),
      .writeData1(WriteData1),
      .readData  (ReadData[k*DATA_W +: DATA_W])
    );
  end

endmodule
